frame_parity_checker: RTL
=========================

FRAME_PARITY_CHECKER -- requirements
Module: frame_parity_checker

Interface
REQ-001 Parameter CH, default 4, number of independent serial lanes (1..16).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame before the parity bit (2..64).
REQ-003 Parameter CNT_W, default 8, width of each per-lane error counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 x  input  CH  serial data bit per lane, bit i belongs to lane i.
REQ-007 x_valid  input  CH  lane i bit accepted on a clock edge when x_valid[i]=1.
REQ-008 odd_mode  input  1  0 = even parity, 1 = odd parity; global, sampled when a parity bit is accepted.
REQ-009 sync_clr  input  1  synchronous abort of all in-progress frames.
REQ-010 z  output  CH  registered running parity (XOR) of data bits accepted so far in the current frame.
REQ-011 frame_done  output  CH  one-cycle pulse: frame completed on lane i.
REQ-012 parity_err  output  CH  one-cycle pulse coincident with frame_done[i] when the check failed.
REQ-013 err_cnt  output  CH*CNT_W  per-lane error counts, lane i in bits [i*CNT_W +: CNT_W]; present only with the macro in REQ-029.

Function
REQ-014 Each lane SHALL run an independent two-state FSM: DATA and PAR.
REQ-015 In DATA, an accepted bit SHALL do acc <= acc ^ x and bitcnt <= bitcnt + 1.
REQ-016 Lane SHALL go DATA->PAR on the accept where bitcnt == DATA_BITS-1; bitcnt then holds DATA_BITS.
REQ-017 In PAR, an accepted bit is the parity bit; err = acc ^ x ^ odd_mode (odd_mode sampled that cycle).
REQ-018 On the parity accept: frame_done[i]=1 next cycle; parity_err[i]=err next cycle; acc<=0, bitcnt<=0, state<=DATA.
REQ-019 frame_done and parity_err SHALL be single-cycle pulses; back-to-back frames SHALL be supported with no idle cycle.
REQ-020 Cycles with x_valid[i]=0 SHALL leave lane i state, acc and bitcnt unchanged and pulses low.
REQ-021 z[i] SHALL equal acc of lane i; it returns to 0 the cycle after a parity accept.
REQ-022 sync_clr=1 SHALL force every lane to DATA with acc=0, bitcnt=0 next cycle; any bit accepted that cycle is discarded; no frame_done/parity_err.
REQ-023 sync_clr SHALL NOT modify err_cnt.
REQ-024 Lanes SHALL NOT interact; simultaneous events on different lanes are all processed in the same cycle.

Reset
REQ-025 reset low SHALL immediately force every lane to DATA, acc=0, bitcnt=0.
REQ-026 During and after reset: z=0, frame_done=0, parity_err=0, err_cnt=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first accepted bit after release is data bit 0.
REQ-028 Reset deassertion is synchronised externally; no internal synchroniser.

Configuration
REQ-029 Macro PARITY_ERR_CNT_EN compiles in the err_cnt port and counters.
REQ-030 With PARITY_ERR_CNT_EN: err_cnt lane i increments by 1 on each cycle parity_err[i] is asserted, saturating at 2^CNT_W-1.
REQ-031 Without PARITY_ERR_CNT_EN: err_cnt port and counters are absent; all other behaviour is identical.

Verification
REQ-032 CH=4, DATA_BITS=8, odd_mode=0, lane0 data 8'b1011_0010 then parity 0 -> frame_done[0] one cycle later, parity_err[0]=0, z[0]=0 afterwards.
REQ-033 Same data with parity 1 -> parity_err[0]=1 with frame_done[0]; err_cnt lane0 = 1 (macro on).
REQ-034 odd_mode=1, lane2 data 8'h00 then parity 1 -> no error; parity 0 -> error; lanes 0,1,3 idle show no pulses.
REQ-035 Lane1 accepts 5 data bits, x_valid gaps inserted, then sync_clr with x_valid=1 -> bit discarded, z[1]=0; next 9 bits form a complete frame with correct check.
REQ-036 CNT_W=2, lane3 sends 5 bad frames back-to-back -> err_cnt lane3 = 1,2,3,3,3; reset low mid-frame -> err_cnt=0, all outputs 0.

Source files
------------

// File: rtl/frame_parity_checker.sv
// Multi-lane serial frame parity checker: DATA_BITS data bits then one parity bit per frame.
// Define PARITY_ERR_CNT_EN to add the err_cnt port with saturating per-lane error counters.
module frame_parity_checker #(
    parameter int CH        = 4,
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       x,
    input  logic [CH-1:0]       x_valid,
    input  logic                odd_mode,
    input  logic                sync_clr,
    output logic [CH-1:0]       z,
    output logic [CH-1:0]       frame_done,
    output logic [CH-1:0]       parity_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CH*CNT_W-1:0] err_cnt
`endif
);

    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic {
        DATA = 1'b0,
        PAR  = 1'b1
    } state_t;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        state_t        state;
        logic          acc;
        logic [BW-1:0] bitcnt;
        logic          done_r;
        logic          err_r;
        logic          par_accept;
        logic          par_bad;

        assign par_accept = !sync_clr && x_valid[i] && (state == PAR);
        assign par_bad    = acc ^ x[i] ^ odd_mode;

        // Per-lane frame FSM; pulses default low and are only raised on a parity accept
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= DATA;
                acc    <= 1'b0;
                bitcnt <= '0;
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end else begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
                if (sync_clr) begin
                    state  <= DATA;
                    acc    <= 1'b0;
                    bitcnt <= '0;
                end else if (x_valid[i]) begin
                    case (state)
                        DATA: begin
                            acc    <= acc ^ x[i];
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BW'(DATA_BITS - 1))
                                state <= PAR;
                        end
                        PAR: begin
                            done_r <= 1'b1;
                            err_r  <= par_bad;
                            acc    <= 1'b0;
                            bitcnt <= '0;
                            state  <= DATA;
                        end
                        default: state <= DATA;
                    endcase
                end
            end
        end

        assign z[i]          = acc;
        assign frame_done[i] = done_r;
        assign parity_err[i] = err_r;

`ifdef PARITY_ERR_CNT_EN
        logic [CNT_W-1:0] cnt;

        // Counter steps together with the parity_err pulse and sticks at all-ones
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                cnt <= '0;
            else if (par_accept && par_bad && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + 1'b1;
        end

        assign err_cnt[i*CNT_W +: CNT_W] = cnt;
`else
        logic unused_par;
        assign unused_par = par_accept ^ par_bad;
`endif
    end

endmodule
